// File: rtl/gpi_irq_pkg.sv
// Shared definitions for the general-purpose input / interrupt CSR block.
// Register offsets are relative to the block's 4-aligned base address.
package gpi_irq_pkg;

  localparam int CSR_AW = 5;
  localparam int CSR_DW = 8;

  localparam logic [1:0] GPI_IN   = 2'd0;
  localparam logic [1:0] GPI_IE   = 2'd1;
  localparam logic [1:0] GPI_IP   = 2'd2;
  localparam logic [1:0] GPI_TYPE = 2'd3;

endpackage

// File: rtl/gpi_debounce.sv
// Input conditioning: two-flop synchroniser, optional tick-based debounce,
// and rise/fall strobes valid on the edge that updates the stable value.
module gpi_debounce
  import gpi_irq_pkg::*;
#(
  parameter int                   NUM_GPIOS    = 8,
  parameter int                   DEBOUNCE_DIV = 0,
  parameter logic [NUM_GPIOS-1:0] DFL_IN       = {NUM_GPIOS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GPIOS-1:0] in,
  output logic [NUM_GPIOS-1:0] stable,
  output logic [NUM_GPIOS-1:0] rise,
  output logic [NUM_GPIOS-1:0] fall
);

  logic [NUM_GPIOS-1:0] sync_p0;
  logic [NUM_GPIOS-1:0] sync_p1;
  logic [NUM_GPIOS-1:0] stable_p2;
  logic [NUM_GPIOS-1:0] stable_nxt;

  // stage p0/p1: metastability guard on the asynchronous pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= DFL_IN;
      sync_p1 <= DFL_IN;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  generate
    if (DEBOUNCE_DIV == 0) begin : g_nodb
      assign stable_nxt = sync_p1;
    end else begin : g_db
      localparam int              CNT_W   = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIV - 1);

      logic [CNT_W-1:0]     cnt;
      logic [NUM_GPIOS-1:0] sample;
      logic [NUM_GPIOS-1:0] agree;
      logic                 tick;

      assign tick  = (cnt == CNT_MAX);
      assign agree = ~(sync_p1 ^ sample);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt    <= '0;
          sample <= DFL_IN;
        end else begin
          cnt <= tick ? '0 : cnt + CNT_W'(1);
          if (tick) sample <= sync_p1;
        end
      end

      // a bit is accepted only when two consecutive ticks saw the same level
      assign stable_nxt = tick ? ((sync_p1 & agree) | (stable_p2 & ~agree)) : stable_p2;
    end
  endgenerate

  // stage p2: accepted input value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_p2 <= DFL_IN;
    end else begin
      stable_p2 <= stable_nxt;
    end
  end

  assign stable = stable_p2;
  assign rise   = ~stable_p2 & stable_nxt;
  assign fall   = stable_p2 & ~stable_nxt;

endmodule

// File: rtl/gpi_irq.sv
// General-purpose input block: IN/IE/IP/TYPE CSRs at four consecutive
// addresses, write-1-to-clear edge latches and a level interrupt.
module gpi_irq
  import gpi_irq_pkg::*;
#(
  parameter logic [CSR_AW-1:0]    BASE_ADDR    = 5'b0,
  parameter int                   NUM_GPIOS    = 8,
  parameter int                   DEBOUNCE_DIV = 0,
  parameter logic [NUM_GPIOS-1:0] DFL_IN       = {NUM_GPIOS{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CSR_AW-1:0]    csr_a,
  input  logic [CSR_DW-1:0]    csr_di,
  input  logic                 csr_we,
  output logic [CSR_DW-1:0]    csr_do,
  input  logic [NUM_GPIOS-1:0] in,
  output logic                 irq
);

  logic [NUM_GPIOS-1:0] stable;
  logic [NUM_GPIOS-1:0] rise;
  logic [NUM_GPIOS-1:0] fall;
  logic [NUM_GPIOS-1:0] ie;
  logic [NUM_GPIOS-1:0] ip;
  logic [NUM_GPIOS-1:0] typ;
  logic [NUM_GPIOS-1:0] ev;
  logic [NUM_GPIOS-1:0] clr;
  logic [NUM_GPIOS-1:0] wdata;
  logic                 sel;
  logic                 wr_ie;
  logic                 wr_ip;
  logic                 wr_typ;

  gpi_debounce #(
    .NUM_GPIOS   (NUM_GPIOS),
    .DEBOUNCE_DIV(DEBOUNCE_DIV),
    .DFL_IN      (DFL_IN)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .stable(stable),
    .rise  (rise),
    .fall  (fall)
  );

  // base is 4-aligned, so the upper address bits select the block
  assign sel    = (csr_a[CSR_AW-1:2] == BASE_ADDR[CSR_AW-1:2]);
  assign wr_ie  = csr_we & sel & (csr_a[1:0] == GPI_IE);
  assign wr_ip  = csr_we & sel & (csr_a[1:0] == GPI_IP);
  assign wr_typ = csr_we & sel & (csr_a[1:0] == GPI_TYPE);
  assign wdata  = csr_di[NUM_GPIOS-1:0];

  assign ev  = (typ & fall) | (~typ & rise);
  assign clr = wr_ip ? wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie  <= '0;
      ip  <= '0;
      typ <= '0;
    end else begin
      if (wr_ie)  ie  <= wdata;
      if (wr_typ) typ <= wdata;
      ip <= (ip & ~clr) | ev;
    end
  end

  always_comb begin
    csr_do = '0;
    if (sel) begin
      case (csr_a[1:0])
        GPI_IN:   csr_do[NUM_GPIOS-1:0] = stable;
        GPI_IE:   csr_do[NUM_GPIOS-1:0] = ie;
        GPI_IP:   csr_do[NUM_GPIOS-1:0] = ip;
        GPI_TYPE: csr_do[NUM_GPIOS-1:0] = typ;
        default:  csr_do = '0;
      endcase
    end
  end

  assign irq = |(ip & ie);

endmodule

// File: tb/tb_gpi_irq.sv
// Bench for gpi_irq: two instances (plain at base 0, debounced 4-pin at 0x10)
// on a shared CSR bus, checked against a history-based behavioural model.
module tb_gpi_irq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] csr_a = '0;
  logic [7:0] csr_di = '0;
  logic       csr_we = 1'b0;
  logic [7:0] pins = '0;
  logic [7:0] do0, do1;
  logic       irq0, irq1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  gpi_irq #(.BASE_ADDR(5'h00), .NUM_GPIOS(8), .DEBOUNCE_DIV(0), .DFL_IN(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do0), .in(pins), .irq(irq0)
  );

  gpi_irq #(.BASE_ADDR(5'h10), .NUM_GPIOS(4), .DEBOUNCE_DIV(4), .DFL_IN(4'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(do1), .in(pins[3:0]), .irq(irq1)
  );

  // Model: pin value applied before each clock edge since reset release,
  // plus the architectural register contents of each instance.
  logic [7:0] hist [0:4095];
  int         k = 0;
  logic [7:0] m_st [2];
  logic [7:0] m_ie [2];
  logic [7:0] m_ip [2];
  logic [7:0] m_ty [2];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hv(input int j);
    return (j >= 1 && j < 4096) ? hist[j] : 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input int d, input logic [4:0] a);
    logic [4:0] b;
    b = (d == 0) ? 5'h00 : 5'h10;
    if (a == b)        return m_st[d];
    if (a == b + 5'd1) return m_ie[d];
    if (a == b + 5'd2) return m_ip[d];
    if (a == b + 5'd3) return m_ty[d];
    return 8'h00;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 8'h00; m_ie[d] = 8'h00; m_ip[d] = 8'h00; m_ty[d] = 8'h00;
    end
  endtask

  task automatic model_edge(input logic [7:0] pin, input logic [4:0] a,
                            input logic [7:0] di, input logic we);
    logic [7:0] nst, cur, prv, ev, clr, msk;
    logic [4:0] b;
    k++;
    if (k < 4096) hist[k] = pin;
    for (int d = 0; d < 2; d++) begin
      msk = (d == 0) ? 8'hFF : 8'h0F;
      b   = (d == 0) ? 5'h00 : 5'h10;
      nst = m_st[d];
      if (d == 0) begin
        nst = hv(k - 2);
      end else if (k % 4 == 0) begin
        cur = hv(k - 2);
        prv = hv(k - 6);
        for (int j = 0; j < 8; j++) if (cur[j] == prv[j]) nst[j] = cur[j];
      end
      nst = nst & msk;
      ev  = (m_ty[d] & m_st[d] & ~nst) | (~m_ty[d] & ~m_st[d] & nst);
      clr = (we && a == b + 5'd2) ? (di & msk) : 8'h00;
      m_ip[d] = (m_ip[d] & ~clr) | ev;
      if (we && a == b + 5'd1) m_ie[d] = di & msk;
      if (we && a == b + 5'd3) m_ty[d] = di & msk;
      m_st[d] = nst;
    end
  endtask

  // Called at a falling edge: drive, compare pre-edge state, advance one clock.
  task automatic step(input logic [7:0] pin, input logic [4:0] a,
                      input logic [7:0] di, input logic we);
    pins = pin; csr_a = a; csr_di = di; csr_we = we;
    #1;
    check("rd0", do0, model_rd(0, a));
    check("rd1", do1, model_rd(1, a));
    check("irq0", {7'b0, irq0}, {7'b0, |(m_ip[0] & m_ie[0])});
    check("irq1", {7'b0, irq1}, {7'b0, |(m_ip[1] & m_ie[1])});
    @(posedge clk);
    model_edge(pin, a, di, we);
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input bit which,
                      input logic [7:0] exp);
    csr_we = 1'b0; csr_a = a;
    #1;
    check(tag, which ? do1 : do0, exp);
  endtask

  task automatic do_reset(input logic [7:0] pin);
    @(posedge clk);
    #2;
    pins = pin; csr_we = 1'b0; rst_n = 1'b0;
    model_reset();
    for (int o = 0; o < 4; o++) begin
      peek("rst_rd0", 5'(o), 1'b0, 8'h00);
      peek("rst_rd1", 5'h10 + 5'(o), 1'b1, 8'h00);
    end
    check("rst_irq", {6'b0, irq1, irq0}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] p;
    @(negedge clk);

    // reset with pins high, then rising events on release
    do_reset(8'hA5);
    repeat (3) step(8'hA5, 5'h00, 8'h00, 1'b0);
    peek("t1_in", 5'h00, 1'b0, 8'hA5);
    peek("t1_ip", 5'h02, 1'b0, 8'hA5);
    check("t1_irq", {7'b0, irq0}, 8'h00);

    // rising edge interrupt and W1C
    step(8'hA5, 5'h02, 8'hFF, 1'b1);
    step(8'hA5, 5'h01, 8'h01, 1'b1);
    repeat (3) step(8'h00, 5'h00, 8'h00, 1'b0);
    repeat (3) step(8'h01, 5'h02, 8'h00, 1'b0);
    check("t2_irq_set", {7'b0, irq0}, 8'h01);
    peek("t2_ip", 5'h02, 1'b0, 8'h01);
    step(8'h01, 5'h02, 8'h01, 1'b1);
    check("t2_irq_clr", {7'b0, irq0}, 8'h00);

    // falling-edge mode on pin1
    step(8'h01, 5'h03, 8'h02, 1'b1);
    step(8'h01, 5'h01, 8'h02, 1'b1);
    repeat (3) step(8'h03, 5'h00, 8'h00, 1'b0);
    step(8'h03, 5'h02, 8'hFF, 1'b1);
    repeat (3) step(8'h01, 5'h02, 8'h00, 1'b0);
    peek("t3_ip_fall", 5'h02, 1'b0, 8'h02);
    check("t3_irq", {7'b0, irq0}, 8'h01);
    repeat (3) step(8'h03, 5'h02, 8'h00, 1'b0);
    peek("t3_ip_rise", 5'h02, 1'b0, 8'h02);

    // clear and set of pin2 on the same edge: set wins
    step(8'h03, 5'h02, 8'hFF, 1'b1);
    step(8'h07, 5'h02, 8'h00, 1'b0);
    step(8'h07, 5'h02, 8'h00, 1'b0);
    step(8'h07, 5'h02, 8'h04, 1'b1);
    peek("t4_ip", 5'h02, 1'b0, 8'h04);

    // debounce: short pulse rejected, held level accepted once
    repeat (12) step(8'h07, 5'h10, 8'h00, 1'b0);
    step(8'h07, 5'h12, 8'hFF, 1'b1);
    step(8'h07, 5'h11, 8'h08, 1'b1);
    repeat (3) step(8'h0F, 5'h10, 8'h00, 1'b0);
    repeat (12) step(8'h07, 5'h10, 8'h00, 1'b0);
    peek("t5_in_pulse", 5'h10, 1'b1, 8'h07);
    peek("t5_ip_pulse", 5'h12, 1'b1, 8'h00);
    repeat (12) step(8'h0F, 5'h12, 8'h00, 1'b0);
    peek("t5_in_held", 5'h10, 1'b1, 8'h0F);
    peek("t5_ip_held", 5'h12, 1'b1, 8'h08);
    check("t5_irq", {7'b0, irq1}, 8'h01);

    // address decode
    peek("t6_0f_a", 5'h0F, 1'b0, 8'h00);
    peek("t6_0f_b", 5'h0F, 1'b1, 8'h00);
    peek("t6_14", 5'h14, 1'b1, 8'h00);
    step(8'h0F, 5'h10, 8'hFF, 1'b1);
    peek("t6_in_ro", 5'h10, 1'b1, 8'h0F);
    step(8'h0F, 5'h11, 8'hFF, 1'b1);
    peek("t6_ie_w", 5'h11, 1'b1, 8'h0F);

    // reset in the middle of debouncing, pins back at default
    repeat (5) step(8'h00, 5'h10, 8'h00, 1'b0);
    do_reset(8'h00);
    repeat (12) step(8'h00, 5'h12, 8'h00, 1'b0);
    peek("t7_ip0", 5'h02, 1'b0, 8'h00);
    peek("t7_ip1", 5'h12, 1'b1, 8'h00);

    // randomized traffic
    p = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] a;
      logic [7:0] d;
      logic       w;
      if ($urandom_range(0, 7) == 0) p = p ^ 8'($urandom);
      case ($urandom_range(0, 2))
        0:       a = 5'($urandom_range(0, 3));
        1:       a = 5'h10 + 5'($urandom_range(0, 3));
        default: a = 5'($urandom);
      endcase
      d = 8'($urandom);
      w = ($urandom_range(0, 3) == 0);
      if (i == 700) do_reset(p);
      step(p, a, d, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpi_irq.md
Name: gpi_irq

Overview:
- General-purpose input block on the CSR bus: the read/interrupt counterpart to the output-only GPO block.
- Synchronises up to 8 external input pins and optionally debounces them.
- Latches per-pin edge events into write-1-to-clear pending bits and drives a level interrupt to the interrupt controller.
- Occupies four consecutive CSR addresses starting at BASE_ADDR.

Parameters:
- BASE_ADDR, 5'b0, first CSR address; must be 4-aligned (BASE_ADDR[1:0] == 0).
- NUM_GPIOS, 8, number of inputs, range 1..8.
- DEBOUNCE_DIV, 0, debounce tick period in clk cycles; 0 = debounce disabled.
- DFL_IN, {NUM_GPIOS{1'b0}}, reset value of the stable-input register and of both synchroniser stages.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- csr_a  in  5  CSR address.
- csr_di  in  8  CSR write data.
- csr_we  in  1  CSR write strobe, one clk per write.
- csr_do  out  8  CSR read data, combinational.
- in  in  NUM_GPIOS  asynchronous external pins.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rst_n. While rst_n is low:
  - sync stages and stable register = DFL_IN.
  - debounce sample register = DFL_IN; tick counter = 0.
  - IE = 0, IP = 0, TYPE = 0, so irq = 0.
  - csr_do stays purely address-decoded.
- Register map (offset from BASE_ADDR); unused upper bits read 0 and ignore writes:
  - +0 IN: read-only, stable input value.
  - +1 IE: read/write, per-pin interrupt enable.
  - +2 IP: read, write-1-to-clear pending bits.
  - +3 TYPE: read/write per pin; 0 = rising edge, 1 = falling edge.
- Read path: csr_do = zero-extended register when csr_a matches one of the four addresses, else 8'b0.
- Synchroniser: two flops per pin, sync2 <= sync1 <= in.
- DEBOUNCE_DIV == 0:
  - stable <= sync2 every clk.
  - Pin change to IN visible: 3 clk edges.
- DEBOUNCE_DIV > 0:
  - Counter runs 0..DEBOUNCE_DIV-1 and wraps; tick is high while counter == DEBOUNCE_DIV-1.
  - On tick: sample <= sync2, and per bit, if sync2 == sample then stable <= sync2.
  - A level is accepted only if seen identical at two consecutive ticks. Glitches shorter than one tick period never reach stable.
  - Acceptance latency: 2 sync edges + 1 to 2 tick periods.
- Edge detect: evaluated at the same edge that updates stable, using the old value of stable.
  - rise = ~stable & new; fall = stable & ~new.
  - ev = TYPE ? fall : rise.
  - IP is set per bit where ev = 1, regardless of IE.
- W1C: write to IP clears bits where csr_di = 1. If a set and a clear hit the same bit in the same cycle, set wins.
- irq = |(IP & IE), combinational from registers.
  - Asserted in the cycle after the edge that sets IP.
  - Drops in the cycle after the clearing write or the IE write.
- Writing IE with pending bits already set asserts irq immediately; pending bits are not masked out.
- Writing TYPE does not generate events and does not modify IP.
- Reset asserted mid-debounce: all state returns to reset values immediately. No event is generated on release unless a pin differs from DFL_IN after synchronisation.

Decomposition:
- Shared package: register offset constants (GPI_IN=0, GPI_IE=1, GPI_IP=2, GPI_TYPE=3).
- Sub-module gpi_debounce (parameters NUM_GPIOS, DEBOUNCE_DIV, DFL_IN). Contains the synchroniser, tick counter, sample/stable registers and edge outputs rise/fall.
- gpi_irq contains only the CSR decode, IE/IP/TYPE registers and irq.

Test Plan:
1. Reset: rst_n low with in=8'hA5 held → IN, IE, IP, TYPE read 0 and irq=0. After release with DEBOUNCE_DIV=0, IN reads 8'hA5 after 3 clks, IP reads 8'hA5 (rising edges from 0), irq stays 0.
2. Rising edge, DEBOUNCE_DIV=0: IE=8'h01, TYPE=0, pin0 0→1 at edge 0 → IP[0]=1 at edge 3, irq=1 from edge 3 on. Write IP=8'h01 → irq=0 the next cycle.
3. Falling mode: TYPE=8'h02, IE=8'h02, pin1 1→0 → IP=8'h02. A later rising edge on pin1 leaves IP unchanged.
4. Simultaneous W1C and event: time a write IP=8'h04 on the same edge pin2's rising edge reaches stable → IP[2] remains 1.
5. Debounce, DEBOUNCE_DIV=4:
   - 3-clk pulse on pin3 → IN[3] and IP[3] unchanged.
   - Level held 12 clks → IN[3]=1 within 2 syncs + 8 clks, one IP[3] set.
6. Address decode, BASE_ADDR=5'h10:
   - Reads of 5'h0F and 5'h14 → csr_do=0.
   - Write 8'hFF to 5'h10 (IN) → no effect.
   - NUM_GPIOS=4: IE write 8'hFF reads back 8'h0F.
